// File: rtl/eth_rx_frame_ring.sv
// Multi-slot receive frame ring: the MAC stream fills slots in order and the host drains them oldest-first.
// Good frames are committed with their length; errored, oversized or no-slot frames are dropped and counted.
module eth_rx_frame_ring #(
  parameter int DATA_W      = 8,
  parameter int SLOT_ADDR_W = 11,
  parameter int NUM_SLOTS   = 4,
  localparam int SLOT_SEL_W = $clog2(NUM_SLOTS)
) (
  input  logic                              clk_clk,
  input  logic                              reset_reset,
  input  logic                              snk_valid,
  input  logic [DATA_W-1:0]                 snk_data,
  input  logic                              snk_sop,
  input  logic                              snk_eop,
  input  logic                              snk_error,
  output logic                              snk_ready,
  input  logic [SLOT_SEL_W+SLOT_ADDR_W-1:0] host_address,
  input  logic                              host_chipselect,
  input  logic                              host_clken,
  output logic [DATA_W-1:0]                 host_readdata,
  input  logic                              host_irq_enable,
  input  logic                              host_release,
  output logic                              ready_valid,
  output logic [SLOT_SEL_W-1:0]             ready_slot,
  output logic [SLOT_ADDR_W:0]              ready_len,
  output logic                              irq,
  output logic [15:0]                       drop_count
);

  localparam int DEPTH = 1 << (SLOT_SEL_W + SLOT_ADDR_W);
  localparam int LEN_W = SLOT_ADDR_W + 1;
  localparam logic [SLOT_SEL_W:0]    FULL_CNT = (SLOT_SEL_W+1)'(NUM_SLOTS);
  localparam logic [SLOT_SEL_W:0]    CNT_ONE  = (SLOT_SEL_W+1)'(1);
  localparam logic [SLOT_SEL_W-1:0]  SEL_ONE  = SLOT_SEL_W'(1);
  localparam logic [SLOT_ADDR_W-1:0] OFF_ONE  = SLOT_ADDR_W'(1);
  localparam logic [SLOT_ADDR_W-1:0] OFF_LAST = '1;
  localparam logic [LEN_W-1:0]       LEN_ONE  = LEN_W'(1);

  typedef enum logic [1:0] {IDLE, FILL, DROP} state_e;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [LEN_W-1:0]  len_q [NUM_SLOTS];

  state_e                 state_q, state_d;
  logic [SLOT_ADDR_W-1:0] wptr_q, wptr_d;
  logic [SLOT_SEL_W-1:0]  wr_idx_q, rd_idx_q, rd_idx_d;
  logic [SLOT_SEL_W:0]    count_q, count_d;
  logic                   ready_valid_q, irq_q, snk_ready_q;
  logic [SLOT_SEL_W-1:0]  ready_slot_q;
  logic [LEN_W-1:0]       ready_len_q, ready_len_d;
  logic [15:0]            drop_cnt_q;
  logic [DATA_W-1:0]      rdata_q;

  logic                   we, commit, drop, start_ok, release_ok;
  logic [SLOT_ADDR_W-1:0] woff;
  logic [LEN_W-1:0]       commit_len;

  // Writer FSM next state; an sop in FILL restarts in the same slot, so it never needs a free slot.
  always_comb begin
    state_d    = state_q;
    wptr_d     = wptr_q;
    we         = 1'b0;
    woff       = wptr_q;
    commit     = 1'b0;
    commit_len = {1'b0, wptr_q} + LEN_ONE;
    drop       = 1'b0;
    start_ok   = (state_q == FILL) || (count_q != FULL_CNT);
    if (snk_valid) begin
      if (snk_sop) begin
        if (state_q == FILL) drop = 1'b1;
        if (start_ok) begin
          we     = 1'b1;
          woff   = '0;
          wptr_d = OFF_ONE;
          if (snk_eop) begin
            state_d    = IDLE;
            commit_len = LEN_ONE;
            if (snk_error) drop = 1'b1;
            else           commit = 1'b1;
          end else begin
            state_d = FILL;
          end
        end else begin
          drop    = 1'b1;
          state_d = snk_eop ? IDLE : DROP;
        end
      end else if (state_q == FILL) begin
        we     = 1'b1;
        wptr_d = wptr_q + OFF_ONE;
        if (snk_eop) begin
          state_d = IDLE;
          if (snk_error) drop = 1'b1;
          else           commit = 1'b1;
        end else if (wptr_q == OFF_LAST) begin
          drop    = 1'b1;
          state_d = DROP;
        end
      end else if ((state_q == DROP) && snk_eop) begin
        state_d = IDLE;
      end
    end
  end

  // Ring bookkeeping; the length bypass covers a commit into the slot that becomes the ready one.
  always_comb begin
    release_ok = host_release && (count_q != '0);
    rd_idx_d   = release_ok ? rd_idx_q + SEL_ONE : rd_idx_q;
    count_d    = count_q;
    case ({commit, release_ok})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
    ready_len_d = (commit && (wr_idx_q == rd_idx_d)) ? commit_len : len_q[rd_idx_d];
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state_q       <= IDLE;
      wptr_q        <= '0;
      wr_idx_q      <= '0;
      rd_idx_q      <= '0;
      count_q       <= '0;
      ready_valid_q <= 1'b0;
      ready_slot_q  <= '0;
      ready_len_q   <= '0;
      irq_q         <= 1'b0;
      drop_cnt_q    <= '0;
      snk_ready_q   <= 1'b0;
      rdata_q       <= '0;
    end else begin
      state_q       <= state_d;
      wptr_q        <= wptr_d;
      rd_idx_q      <= rd_idx_d;
      count_q       <= count_d;
      ready_valid_q <= (count_d != '0);
      ready_slot_q  <= rd_idx_d;
      ready_len_q   <= ready_len_d;
      irq_q         <= host_irq_enable && (count_d != '0);
      snk_ready_q   <= 1'b1;
      if (commit) wr_idx_q <= wr_idx_q + SEL_ONE;
      if (drop && (drop_cnt_q != 16'hFFFF)) drop_cnt_q <= drop_cnt_q + 16'd1;
      if (host_chipselect && host_clken) rdata_q <= mem_q[host_address];
    end
  end

  // Frame storage and length table are deliberately left uninitialised by reset.
  always_ff @(posedge clk_clk) begin
    if (we && !reset_reset) mem_q[{wr_idx_q, woff}] <= snk_data;
    if (commit && !reset_reset) len_q[wr_idx_q] <= commit_len;
  end

  assign snk_ready     = snk_ready_q;
  assign host_readdata = rdata_q;
  assign ready_valid   = ready_valid_q;
  assign ready_slot    = ready_slot_q;
  assign ready_len     = ready_len_q;
  assign irq           = irq_q;
  assign drop_count    = drop_cnt_q;

endmodule

// File: tb/tb_eth_rx_frame_ring.sv
// Self-checking bench for eth_rx_frame_ring: frame-level reference model checked every cycle,
// plus literal expectations for the directed scenarios.
module tb_eth_rx_frame_ring;

  localparam int NUM_SLOTS  = 4;
  localparam int SLOT_BYTES = 2048;

  logic        clk_clk = 1'b0;
  logic        reset_reset = 1'b1;
  logic        snk_valid = 1'b0;
  logic [7:0]  snk_data = '0;
  logic        snk_sop = 1'b0;
  logic        snk_eop = 1'b0;
  logic        snk_error = 1'b0;
  logic        snk_ready;
  logic [12:0] host_address = '0;
  logic        host_chipselect = 1'b0;
  logic        host_clken = 1'b0;
  logic [7:0]  host_readdata;
  logic        host_irq_enable = 1'b0;
  logic        host_release = 1'b0;
  logic        ready_valid;
  logic [1:0]  ready_slot;
  logic [11:0] ready_len;
  logic        irq;
  logic [15:0] drop_count;

  eth_rx_frame_ring dut (
    .clk_clk        (clk_clk),
    .reset_reset    (reset_reset),
    .snk_valid      (snk_valid),
    .snk_data       (snk_data),
    .snk_sop        (snk_sop),
    .snk_eop        (snk_eop),
    .snk_error      (snk_error),
    .snk_ready      (snk_ready),
    .host_address   (host_address),
    .host_chipselect(host_chipselect),
    .host_clken     (host_clken),
    .host_readdata  (host_readdata),
    .host_irq_enable(host_irq_enable),
    .host_release   (host_release),
    .ready_valid    (ready_valid),
    .ready_slot     (ready_slot),
    .ready_len      (ready_len),
    .irq            (irq),
    .drop_count     (drop_count)
  );

  always #5 clk_clk = ~clk_clk;

  int checkCount = 0;
  int errCount   = 0;
  bit checkEn    = 1'b0;

  // Reference model: pending frames as a queue, plus a byte image of the buffer.
  int         pendSlot[$];
  int         pendLen[$];
  int         wrSlot;
  int         dropCnt;
  bit         openFrame;
  bit         irqEnQ;
  logic [7:0] expRdata;
  logic [7:0] modelMem [0:NUM_SLOTS*SLOT_BYTES-1];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [7:0] d, input logic sop, input logic eop,
                               input logic err, input logic rel, input logic cs, input logic ce,
                               input logic [12:0] addr);
    snk_valid       = v;
    snk_data        = d;
    snk_sop         = sop;
    snk_eop         = eop;
    snk_error       = err;
    host_release    = rel;
    host_chipselect = cs;
    host_clken      = ce;
    host_address    = addr;
    @(posedge clk_clk);
    #1;
    irqEnQ = host_irq_enable;
    if (cs && ce) expRdata = modelMem[int'(addr)];
    snk_valid       = 1'b0;
    snk_sop         = 1'b0;
    snk_eop         = 1'b0;
    snk_error       = 1'b0;
    host_release    = 1'b0;
    host_chipselect = 1'b0;
    host_clken      = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 8'h00, 0, 0, 0, 0, 0, 0, 13'h0);
  endtask

  task automatic doReset();
    checkEn     = 1'b0;
    reset_reset = 1'b1;
    idle(2);
    checkOutput("resetReadyValid", 32'(ready_valid), 32'd0);
    checkOutput("resetIrq", 32'(irq), 32'd0);
    checkOutput("resetDropCount", 32'(drop_count), 32'd0);
    checkOutput("resetReadData", 32'(host_readdata), 32'd0);
    checkOutput("resetSnkReady", 32'(snk_ready), 32'd0);
    pendSlot.delete();
    pendLen.delete();
    wrSlot      = 0;
    dropCnt     = 0;
    openFrame   = 1'b0;
    expRdata    = 8'h00;
    reset_reset = 1'b0;
    idle(1);
    checkEn = 1'b1;
  endtask

  // Frame-level outcome: no slot -> dropped at sop; >2048 beats -> dropped at beat 2047;
  // error -> dropped at eop; otherwise committed at eop. An sop into an open frame aborts it.
  task automatic sendFrame(input int n, input bit err, input bit withEop, input bit relOnEop,
                           input logic [7:0] seed);
    bit         accept, wasOpen, last;
    int         slot;
    logic [7:0] d;
    wasOpen = openFrame;
    accept  = wasOpen || (pendSlot.size() < NUM_SLOTS);
    slot    = wrSlot;
    for (int i = 0; i < n; i++) begin
      last = withEop && (i == n - 1);
      d    = seed + 8'(i);
      applyStimulus(1, d, i == 0, last, last && err, last && relOnEop, 0, 0, 13'h0);
      if (i == 0 && wasOpen) dropCnt++;
      if (i == 0 && !accept) dropCnt++;
      if (accept && i < SLOT_BYTES) modelMem[slot*SLOT_BYTES + i] = d;
      if (accept && i == SLOT_BYTES - 1 && !last) dropCnt++;
      if (last && relOnEop && pendSlot.size() != 0) begin
        void'(pendSlot.pop_front());
        void'(pendLen.pop_front());
      end
      if (last && accept && n <= SLOT_BYTES) begin
        if (err) dropCnt++;
        else begin
          pendSlot.push_back(slot);
          pendLen.push_back(n);
          wrSlot = (wrSlot + 1) % NUM_SLOTS;
        end
      end
    end
    openFrame = accept && !withEop && (n < SLOT_BYTES);
  endtask

  task automatic releaseSlot();
    applyStimulus(0, 8'h00, 0, 0, 0, 1, 0, 0, 13'h0);
    if (pendSlot.size() != 0) begin
      void'(pendSlot.pop_front());
      void'(pendLen.pop_front());
    end
  endtask

  task automatic readByte(input int slot, input int off, input logic [7:0] lit);
    applyStimulus(0, 8'h00, 0, 0, 0, 0, 1, 1, 13'(slot*SLOT_BYTES + off));
    checkOutput("readLiteral", 32'(host_readdata), 32'(lit));
  endtask

  always @(negedge clk_clk) begin
    if (checkEn) begin
      checkOutput("snkReady", 32'(snk_ready), 32'd1);
      checkOutput("readyValid", 32'(ready_valid), 32'(pendSlot.size() != 0));
      if (pendSlot.size() != 0) begin
        checkOutput("readySlot", 32'(ready_slot), 32'(pendSlot[0]));
        checkOutput("readyLen", 32'(ready_len), 32'(pendLen[0]));
      end
      checkOutput("irq", 32'(irq), 32'(irqEnQ && (pendSlot.size() != 0)));
      checkOutput("dropCount", 32'(drop_count), 32'((dropCnt > 65535) ? 65535 : dropCnt));
      checkOutput("readData", 32'(host_readdata), 32'(expRdata));
    end
  end

  initial begin
    #2_000_000;
    errCount++;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // 64-byte good frame, interrupt, read-back, release, read hold
    doReset();
    host_irq_enable = 1'b1;
    sendFrame(64, 0, 1, 0, 8'h00);
    checkOutput("s1ReadyValid", 32'(ready_valid), 32'd1);
    checkOutput("s1Irq", 32'(irq), 32'd1);
    checkOutput("s1Slot", 32'(ready_slot), 32'd0);
    checkOutput("s1Len", 32'(ready_len), 32'd64);
    readByte(0, 5, 8'h05);
    applyStimulus(0, 8'h00, 0, 0, 0, 0, 1, 0, 13'd9);
    checkOutput("s1ReadHold", 32'(host_readdata), 32'h05);
    releaseSlot();
    checkOutput("s1IrqOff", 32'(irq), 32'd0);
    checkOutput("s1ValidOff", 32'(ready_valid), 32'd0);

    // Ring fills, fifth frame dropped, wrap back to slot 0
    doReset();
    host_irq_enable = 1'b0;
    for (int f = 0; f < 5; f++) sendFrame(60, 0, 1, 0, 8'(8'h10 * (f + 1)));
    checkOutput("s2Drop", 32'(drop_count), 32'd1);
    checkOutput("s2Slot0", 32'(ready_slot), 32'd0);
    readByte(3, 0, 8'h40);
    releaseSlot();
    checkOutput("s2Slot1", 32'(ready_slot), 32'd1);
    sendFrame(60, 0, 1, 0, 8'h60);
    releaseSlot();
    checkOutput("s2Slot2", 32'(ready_slot), 32'd2);
    releaseSlot();
    checkOutput("s2Slot3", 32'(ready_slot), 32'd3);
    releaseSlot();
    checkOutput("s2SlotWrap", 32'(ready_slot), 32'd0);
    checkOutput("s2WrapLen", 32'(ready_len), 32'd60);
    readByte(0, 1, 8'h61);

    // Errored frame
    doReset();
    host_irq_enable = 1'b1;
    sendFrame(30, 1, 1, 0, 8'h22);
    idle(2);
    checkOutput("s3Drop", 32'(drop_count), 32'd1);
    checkOutput("s3Valid", 32'(ready_valid), 32'd0);

    // Oversized then exact full-slot frame
    doReset();
    sendFrame(2049, 0, 1, 0, 8'h00);
    checkOutput("s4Drop", 32'(drop_count), 32'd1);
    checkOutput("s4Valid", 32'(ready_valid), 32'd0);
    sendFrame(2048, 0, 1, 0, 8'hA0);
    checkOutput("s4Len", 32'(ready_len), 32'd2048);
    checkOutput("s4Slot", 32'(ready_slot), 32'd0);
    readByte(0, 2047, 8'h9F);

    // sop into an open frame restarts in the same slot
    doReset();
    sendFrame(10, 0, 0, 0, 8'h11);
    sendFrame(20, 0, 1, 0, 8'h80);
    checkOutput("s5Drop", 32'(drop_count), 32'd1);
    checkOutput("s5Len", 32'(ready_len), 32'd20);
    checkOutput("s5Slot", 32'(ready_slot), 32'd0);
    readByte(0, 0, 8'h80);
    readByte(0, 15, 8'h8F);

    // Commit and release together, then a single-beat frame
    doReset();
    sendFrame(5, 0, 1, 0, 8'h01);
    sendFrame(7, 0, 1, 0, 8'h02);
    sendFrame(9, 0, 1, 1, 8'h03);
    checkOutput("s6Slot", 32'(ready_slot), 32'd1);
    checkOutput("s6Len", 32'(ready_len), 32'd7);
    releaseSlot();
    checkOutput("s6Slot2", 32'(ready_slot), 32'd2);
    checkOutput("s6Len2", 32'(ready_len), 32'd9);
    checkOutput("s6Valid2", 32'(ready_valid), 32'd1);
    releaseSlot();
    checkOutput("s6Empty", 32'(ready_valid), 32'd0);
    releaseSlot();
    sendFrame(1, 0, 1, 0, 8'hC5);
    checkOutput("s6OneLen", 32'(ready_len), 32'd1);
    checkOutput("s6OneSlot", 32'(ready_slot), 32'd3);
    readByte(3, 0, 8'hC5);

    // Reset mid-frame abandons the frame without counting it
    doReset();
    sendFrame(5, 0, 0, 0, 8'h33);
    doReset();
    sendFrame(3, 0, 1, 0, 8'h44);
    checkOutput("s7Drop", 32'(drop_count), 32'd0);
    checkOutput("s7Slot", 32'(ready_slot), 32'd0);
    checkOutput("s7Len", 32'(ready_len), 32'd3);
    idle(3);

    checkEn = 1'b0;
    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule

// File: doc/eth_rx_frame_ring.md
Name: eth_rx_frame_ring

Overview:
- Parametrised multi-slot receive frame buffer. It generalises the single 2 KB byte-wide MAC/CPU shared buffer into NUM_SLOTS frame slots managed as a ring.
- Sits between the MAC receive stream (sink side) and the host processor (byte read port plus slot handshake).
- Commits each good frame with its length and raises a level interrupt while frames are pending.
- Drops errored, oversized or no-slot frames and counts them.

Parameters:
- DATA_W, 8, stream and host data width in bits.
- SLOT_ADDR_W, 11, log2 of slot depth in words (2048 per slot).
- NUM_SLOTS, 4, number of frame slots; power of two, 2 to 16.
- SLOT_SEL_W, log2(NUM_SLOTS), slot index width (derived, not overridden).

Ports:
- clk_clk  in  1  single clock for all logic.
- reset_reset  in  1  synchronous, active-high reset.
- snk_valid  in  1  stream beat valid.
- snk_data  in  DATA_W  stream data.
- snk_sop  in  1  first beat of frame.
- snk_eop  in  1  last beat of frame.
- snk_error  in  1  frame error, sampled on eop beat.
- snk_ready  out  1  always 1 out of reset (no backpressure; drop policy).
- host_address  in  SLOT_SEL_W+SLOT_ADDR_W  {slot, offset} read address.
- host_chipselect  in  1  read select.
- host_clken  in  1  read clock enable.
- host_readdata  out  DATA_W  read data.
- host_irq_enable  in  1  interrupt mask.
- host_release  in  1  one-cycle pulse: host done with ready slot.
- ready_valid  out  1  at least one committed frame pending.
- ready_slot  out  SLOT_SEL_W  oldest pending slot index.
- ready_len  out  SLOT_ADDR_W+1  byte length of ready_slot frame.
- irq  out  1  level interrupt.
- drop_count  out  16  saturating dropped-frame counter.

Behaviour:
- Reset (clk_clk edge with reset_reset=1):
  - state=IDLE; wr_idx, rd_idx, count, wptr = 0.
  - ready_valid=0, irq=0, drop_count=0, host_readdata=0, snk_ready=0 during reset and 1 afterwards.
  - Memory and length table are not cleared.
  - Reset mid-frame abandons the frame without counting it.
- Writer FSM, states IDLE, FILL, DROP. Only beats with snk_valid=1 are processed.
- IDLE:
  - sop beat with count<NUM_SLOTS: write mem[wr_idx][0], set wptr=1, go to FILL.
  - If the same beat also has eop: commit or discard immediately, len=1, stay in IDLE.
  - sop beat with count==NUM_SLOTS: drop_count++ and go to DROP (if also eop, stay in IDLE).
  - Non-sop beats are ignored.
- FILL:
  - Each beat writes mem[wr_idx][wptr], then wptr++.
  - eop beat, snk_error=0: commit, with len_table[wr_idx]=wptr+1, wr_idx++, count++, go to IDLE.
  - eop beat, snk_error=1: discard, drop_count++, go to IDLE.
  - Non-eop beat at wptr==2^SLOT_ADDR_W-1: beat is written, frame is oversized; drop_count++, go to DROP.
  - An eop beat at that same wptr is a legal full-slot frame, len=2^SLOT_ADDR_W.
  - sop beat in FILL: current frame is aborted, drop_count++. The new frame restarts at offset 0 of the same slot.
- DROP:
  - Beats are discarded until eop, then go to IDLE.
  - An sop beat in DROP is treated exactly as in IDLE (new frame, no extra count for the tail).
- Slot ring:
  - ready_valid = (count!=0); ready_slot = rd_idx; ready_len = len_table[rd_idx]. All are registered and update the cycle after a commit or release.
  - host_release with count!=0: rd_idx++, count--. With count==0 it is ignored.
  - Commit and release in the same cycle: count unchanged, both indices advance.
  - wr_idx and rd_idx wrap modulo NUM_SLOTS.
  - The slot being filled is never the ready slot.
- irq = registered host_irq_enable & (count!=0). It deasserts the cycle after the release that empties the ring.
- drop_count saturates at 16'hFFFF.
- Host read:
  - When host_chipselect & host_clken is set, host_readdata = mem[host_address] on the next cycle (latency 1).
  - Otherwise host_readdata holds its value.
  - Reading the slot currently being filled returns undefined data and is legal.
  - Host writes are not supported.

Test Plan:
- 64-byte good frame (bytes 0x00..0x3F), irq_enable=1 -> ready_valid=1 and irq=1 one cycle after eop, ready_slot=0, ready_len=64; reading address {0,5} returns 0x05 one cycle later; release drops irq next cycle.
- Five 60-byte frames with no release, NUM_SLOTS=4 -> slots 0..3 committed, fifth frame dropped, drop_count=1; release then a new frame -> lands in slot 0 (wrap), ready_slot sequence 0,1,2,3,0.
- Frame with snk_error=1 on eop -> no commit, ready_valid stays 0, drop_count=1.
- 2049-byte frame -> dropped as oversized, drop_count=1; exact 2048-byte frame -> committed, ready_len=2048.
- sop arrives at beat 10 of an open frame, new frame 20 bytes -> drop_count=1, committed ready_len=20 in the same slot.
- Commit and release in the same cycle with count=2 -> count stays 2, ready_slot advances by 1; single-beat sop+eop frame -> ready_len=1.
